// File: rtl/bist_seq_harness_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bist_seq_harness_pkg
// Purpose  : Shared types and next-state helpers for the BIST harness.
//            Holds the run-control state enum and width/mask-parametrised
//            Galois LFSR and MISR step functions. The functions operate on a
//            MAX_W-bit container; callers zero-extend their operands in and
//            truncate the result back to their own width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bist_seq_harness_pkg;

    // Widest pattern or signature the helpers can handle.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // All-ones mask covering the low w bits.
    function automatic logic [MAX_W-1:0] width_mask(input int w);
        if (w >= MAX_W) begin
            return '1;
        end
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    // Galois LFSR step: shift right, fold the mask in when bit 0 falls out.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] p,
                                                   input logic [MAX_W-1:0] taps,
                                                   input int               w);
        logic [MAX_W-1:0] fb;
        fb = p[0] ? taps : '0;
        return ((p >> 1) ^ fb) & width_mask(w);
    endfunction

    // MISR step: shift left, fold the mask in when the top bit falls out,
    // then absorb the parallel response word.
    function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] m,
                                                   input logic [MAX_W-1:0] taps,
                                                   input logic [MAX_W-1:0] d,
                                                   input int               w);
        logic [MAX_W-1:0] fb;
        fb = (((m >> (w - 1)) & MAX_W'(1)) != '0) ? taps : '0;
        return ((m << 1) ^ fb ^ d) & width_mask(w);
    endfunction

endpackage : bist_seq_harness_pkg
`default_nettype wire

// File: rtl/bist_misr.sv
`default_nettype none
// ============================================================================
// Module   : bist_misr
// Purpose  : Multiple-input signature register that compacts one CUT
//            response word per enabled cycle.
// Ports    : clk      - rising-edge clock
//            rst_n    - asynchronous active-low reset (clears signature)
//            clear_i  - synchronous clear, wins over enable_i
//            enable_i - compact data_i this cycle
//            data_i   - response word, OUT_W bits
//            sig_o    - current signature, OUT_W bits
// Revision : 1.0 - initial release
// ============================================================================
module bist_misr
    import bist_seq_harness_pkg::*;
#(
    parameter int               OUT_W     = 14,
    parameter logic [OUT_W-1:0] MISR_TAPS = 14'h2003
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [OUT_W-1:0] data_i,
    output logic [OUT_W-1:0] sig_o
);

    logic [OUT_W-1:0] sig_q;
    logic [OUT_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = '0;
        end else if (enable_i) begin
            sig_d = OUT_W'(misr_next(MAX_W'(sig_q), MAX_W'(MISR_TAPS),
                                     MAX_W'(data_i), OUT_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule : bist_misr
`default_nettype wire

// File: rtl/bist_seq_harness.sv
`default_nettype none
// ============================================================================
// Module   : bist_seq_harness
// Purpose  : Built-in self-test harness. Drives a combinational CUT with an
//            LFSR or exhaustive-counter pattern stream, compacts the CUT
//            responses in a MISR and compares the final signature against
//            GOLDEN. Start/busy/done handshake with abort.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            start     - one-cycle run request (ignored while running)
//            abort     - cancel run, return to idle; wins over start
//            mode      - 0 = LFSR, 1 = binary counter; sampled with start
//            cut_in    - registered pattern to the CUT, IN_W bits
//            cut_out   - CUT response, OUT_W bits
//            busy      - run in progress
//            done      - run complete, held until next start or abort
//            pass      - signature == GOLDEN, meaningful while done
//            signature - MISR contents, OUT_W bits
// Revision : 1.0 - initial release
// ============================================================================
module bist_seq_harness
    import bist_seq_harness_pkg::*;
#(
    parameter int               IN_W      = 3,
    parameter int               OUT_W     = 14,
    parameter int               PATTERNS  = 255,
    parameter logic [IN_W-1:0]  LFSR_TAPS = 3'b110,
    parameter logic [OUT_W-1:0] MISR_TAPS = 14'h2003,
    parameter logic [IN_W-1:0]  SEED      = 3'd1,
    parameter logic [OUT_W-1:0] GOLDEN    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    output logic [IN_W-1:0]  cut_in,
    input  logic [OUT_W-1:0] cut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature
);

    localparam int              CNT_W    = $clog2(PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  pat_q,   pat_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             mode_q,  mode_d;
    logic             misr_clr;
    logic             misr_en;
    logic [IN_W-1:0]  pat_lfsr;
    logic [IN_W-1:0]  pat_step;
    logic [OUT_W-1:0] sig;

    assign pat_lfsr = IN_W'(lfsr_next(MAX_W'(pat_q), MAX_W'(LFSR_TAPS), IN_W));
    assign pat_step = mode_q ? (pat_q + IN_W'(1)) : pat_lfsr;

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;

        if (abort) begin
            // Pattern and signature are left untouched for post-mortem.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d  = RUN;
                        pat_d    = mode ? '0 : SEED_EFF;
                        cnt_d    = '0;
                        mode_d   = mode;
                        misr_clr = 1'b1;
                    end
                end
                RUN: begin
                    misr_en = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        // Last response is being compacted; freeze the
                        // pattern so cut_in holds the final vector.
                        state_d = DONE;
                    end else begin
                        pat_d = pat_step;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    bist_misr #(
        .OUT_W     (OUT_W),
        .MISR_TAPS (MISR_TAPS)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (misr_clr),
        .enable_i (misr_en),
        .data_i   (cut_out),
        .sig_o    (sig)
    );

    // All outputs come from registers; cut_out only reaches them via the MISR.
    assign cut_in    = pat_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (sig == GOLDEN);
    assign signature = sig;

endmodule : bist_seq_harness
`default_nettype wire

// File: doc/bist_seq_harness.md
# bist_seq_harness

Parametrised built-in self-test harness that drives a combinational test circuit with a pattern stream and compacts its responses into a signature. It generalises the team's fixed-width combinational benchmark circuits by adding configurable input/output widths, a pattern generator selectable between LFSR and exhaustive-counter mode, a MISR compactor, and a start/busy/done handshake. It sits between the bench controller and any combinational circuit under test (CUT) in the benchmark set.

## Interface
- IN_W, 3: CUT input width (≥2).
- OUT_W, 14: CUT output width and MISR width (≥2).
- PATTERNS, 255: patterns applied per run (≥1).
- LFSR_TAPS, 3'b110: Galois feedback mask, IN_W bits.
- MISR_TAPS, 14'h2003: MISR feedback mask, OUT_W bits.
- SEED, 1: LFSR start value. A SEED of 0 is replaced by 1.
- GOLDEN, 0: expected signature, OUT_W bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request
- abort  in  1  cancel run
- mode  in  1  0 = LFSR patterns, 1 = exhaustive binary counter; sampled with start
- cut_in  out  IN_W  registered pattern to the CUT
- cut_out  in  OUT_W  CUT response; combinational from cut_in
- busy  out  1  run in progress
- done  out  1  run complete; held until the next start
- pass  out  1  signature == GOLDEN; valid while done
- signature  out  OUT_W  MISR contents

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE or DONE, with start=1 and abort=0:
  - Go to RUN.
  - Load the pattern register with the mode's first pattern: SEED' in LFSR mode, 0 in counter mode.
  - Clear the MISR and the pattern counter; clear done and pass.
  - Latch mode.
- RUN, each cycle:
  - Update the MISR: misr <= {misr[OUT_W-2:0],1'b0} ^ (misr[OUT_W-1] ? MISR_TAPS : 0) ^ cut_out.
  - Advance the pattern register. In LFSR mode (Galois): p <= (p>>1) ^ (p[0] ? LFSR_TAPS : 0). In counter mode: p <= p+1, wrapping modulo 2^IN_W.
  - Increment the counter. When it reaches PATTERNS-1, go to DONE.
- Entering DONE:
  - done=1, busy=0.
  - pass computed from the final MISR value.
  - The pattern register holds its value.
- start in RUN is ignored.
- abort in any state:
  - Go to IDLE next cycle; done=0, pass=0, busy=0.
  - MISR and cut_in are retained.
  - abort takes precedence over start in the same cycle.
- Counter width is $clog2(PATTERNS+1). Patterns repeat when PATTERNS exceeds the sequence period; this is legal.
- rst_n low mid-run: everything returns to reset values immediately. No partial signature survives.

## Timing
- Reset values: state IDLE, cut_in=0, busy=0, done=0, pass=0, signature=0, counter=0.
- start sampled at edge t:
  - busy=1 from t+1.
  - cut_in shows pattern k during cycle t+1+k, for k = 0..PATTERNS-1.
  - The response to pattern k is compacted at edge t+2+k.
- done=1 and busy=0 from cycle t+1+PATTERNS. Latency is PATTERNS+1 cycles.
- signature and pass are stable while done=1.
- Back-to-back runs: a start in the first DONE cycle begins a new run at the next edge.
- No combinational path from cut_out to any output.

## Structure
- A shared package holds the state enum (IDLE/RUN/DONE) and the LFSR/MISR next-state functions, parametrised by width and mask.
- One sub-module, bist_misr (OUT_W, MISR_TAPS), has:
  - clear, enable and data inputs
  - the sig output
- The pattern generator and FSM stay in the top level.

## Test plan
- IN_W=3, OUT_W=3, MISR_TAPS=3'b011, mode=1, PATTERNS=2, cut_out=cut_in loopback, start → cut_in 0 then 1; done after 3 cycles; signature=3'b001; pass=1 with GOLDEN=1.
- Same setup with PATTERNS=3 → patterns 0,1,2; signature=3'b000; pass=0 with GOLDEN=1.
- mode=0, SEED=1, LFSR_TAPS=3'b110, PATTERNS=7 → cut_in sequence 1,6,3,7,5,4,2 (period 7, no zero); done at cycle 8.
- SEED=0, mode=0 → first pattern 1.
- cut_out tied 0, PATTERNS=255 → signature=0, pass=1 with GOLDEN=0. busy high for exactly 255 cycles.
- abort asserted on RUN cycle 4 together with start → IDLE next cycle, done=0, busy=0, no restart. Then start → full fresh run with correct signature.
- rst_n pulsed low mid-run (async, between edges) → all outputs 0 immediately. A subsequent start runs normally.
- start held high during RUN → ignored. After done, start in the first DONE cycle → busy next cycle, done cleared.
